// File: rtl/code_decoder_fifo.sv
// Small FIFO of 3-bit codes; the oldest entry is presented on dout as a one-hot decode.
// Handshakes use valid/ready on both sides, and in_ready depends only on registered occupancy.
module code_decoder_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               code_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               dout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Status flags come straight from the count register, so there is no path from out_ready to in_ready.
    always_comb begin
        in_ready  = (count != FULL);
        out_valid = (count != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    always_comb begin
        dout = 8'h00;
        if (out_valid) begin
            dout = 8'd1 << mem[rd_ptr];
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= code_in;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_code_decoder_fifo.sv
// Scoreboard bench for code_decoder_fifo: scenario tasks queue the expected decodes as they
// drive codes in, and a negedge monitor pops and compares every word the DUT hands out.
module tb_code_decoder_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] code_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dout;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;

    logic [7:0] sb [$];
    logic [7:0] exp_data;
    int         checks = 0;
    int         errors = 0;

    code_decoder_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .code_in   (code_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Every accepted output word must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_underflow: dout=%h delivered but no code was expected", dout);
            end else begin
                exp_data = sb.pop_front();
                if (dout !== exp_data) begin
                    errors++;
                    $display("[TB] FAIL sb_data: dout=%h expected=%h", dout, exp_data);
                end
            end
        end
    end

    task automatic test_reset();
        #2;
        checks += 4;
        if (count !== 3'd0)     begin errors++; $display("[TB] FAIL rst_count: got=%0d exp=0", count); end
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got=%b exp=0", out_valid); end
        if (dout !== 8'h00)     begin errors++; $display("[TB] FAIL rst_dout: got=%h exp=00", dout); end
        if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL rst_in_ready: got=%b exp=1", in_ready); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; code_in = 3'd5; sb.push_back(8'h20);
        @(posedge clk); #1;
        code_in = 3'd2; sb.push_back(8'h04);
        @(posedge clk); #1;
        in_valid = 1'b0; code_in = 3'bxxx;
        @(negedge clk);
        checks += 2;
        if (count !== 3'd2) begin errors++; $display("[TB] FAIL pre_reset_count: got=%0d exp=2", count); end
        if (dout !== 8'h20) begin errors++; $display("[TB] FAIL pre_reset_dout: got=%h exp=20", dout); end
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (count !== 3'd0)     begin errors++; $display("[TB] FAIL async_rst_count: got=%0d exp=0", count); end
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_out_valid: got=%b exp=0", out_valid); end
        if (dout !== 8'h00)     begin errors++; $display("[TB] FAIL async_rst_dout: got=%h exp=00", dout); end
        if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL async_rst_in_ready: got=%b exp=1", in_ready); end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_out_valid: got=%b exp=0", out_valid); end
        if (count !== 3'd0)     begin errors++; $display("[TB] FAIL post_reset_count: got=%0d exp=0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_sweep();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; code_in = 3'(i); sb.push_back(8'(1) << i);
            @(posedge clk); #1;
            in_valid = 1'b0; code_in = 3'bxxx;
            @(negedge clk);
            checks += 2;
            if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL sweep_valid[%0d]: got=%b exp=1", i, out_valid); end
            if (dout !== (8'(1) << i)) begin errors++; $display("[TB] FAIL sweep_dout[%0d]: got=%h exp=%h", i, dout, 8'(1) << i); end
        end
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL sweep_empty_valid: got=%b exp=0", out_valid); end
        if (count !== 3'd0)     begin errors++; $display("[TB] FAIL sweep_empty_count: got=%0d exp=0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [2:0] codes [4];
        logic [7:0] exp_seq [4];
        codes   = '{3'd3, 3'd5, 3'd7, 3'd1};
        exp_seq = '{8'h08, 8'h20, 8'h80, 8'h02};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; code_in = codes[i]; sb.push_back(8'(1) << codes[i]);
        end
        @(posedge clk); #1;
        code_in = 3'd6;
        @(negedge clk);
        checks += 2;
        if (count !== 3'd4)    begin errors++; $display("[TB] FAIL full_count: got=%0d exp=4", count); end
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready: got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks += 3;
        if (count !== 3'd4)        begin errors++; $display("[TB] FAIL full_hold_count: got=%0d exp=4", count); end
        if (in_ready !== 1'b0)     begin errors++; $display("[TB] FAIL full_pop_in_ready: got=%b exp=0", in_ready); end
        if (dout !== exp_seq[0])   begin errors++; $display("[TB] FAIL drain_dout[0]: got=%h exp=%h", dout, exp_seq[0]); end
        @(posedge clk); #1;
        in_valid = 1'b0; code_in = 3'bxxx;
        @(negedge clk);
        checks += 3;
        if (count !== 3'd3)      begin errors++; $display("[TB] FAIL after_pop_count: got=%0d exp=3", count); end
        if (in_ready !== 1'b1)   begin errors++; $display("[TB] FAIL after_pop_in_ready: got=%b exp=1", in_ready); end
        if (dout !== exp_seq[1]) begin errors++; $display("[TB] FAIL drain_dout[1]: got=%h exp=%h", dout, exp_seq[1]); end
        for (int k = 2; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (dout !== exp_seq[k]) begin errors++; $display("[TB] FAIL drain_dout[%0d]: got=%h exp=%h", k, dout, exp_seq[k]); end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: out_valid=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; code_in = 3'd2; sb.push_back(8'h04);
        @(posedge clk); #1;
        code_in = 3'd4; sb.push_back(8'h10);
        @(posedge clk); #1;
        code_in = 3'd6; out_ready = 1'b1; sb.push_back(8'h40);
        @(negedge clk);
        checks += 2;
        if (count !== 3'd2) begin errors++; $display("[TB] FAIL simul_pre_count: got=%0d exp=2", count); end
        if (dout !== 8'h04) begin errors++; $display("[TB] FAIL simul_pre_dout: got=%h exp=04", dout); end
        @(posedge clk); #1;
        in_valid = 1'b0; code_in = 3'bxxx;
        @(negedge clk);
        checks += 2;
        if (count !== 3'd2) begin errors++; $display("[TB] FAIL simul_count: got=%0d exp=2", count); end
        if (dout !== 8'h10) begin errors++; $display("[TB] FAIL simul_dout0: got=%h exp=10", dout); end
        @(posedge clk); #1;
        @(negedge clk);
        checks += 2;
        if (count !== 3'd1) begin errors++; $display("[TB] FAIL simul_count1: got=%0d exp=1", count); end
        if (dout !== 8'h40) begin errors++; $display("[TB] FAIL simul_dout1: got=%h exp=40", dout); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL simul_empty: out_valid=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; code_in = 3'(i % 8); sb.push_back(8'(1) << (i % 8));
            @(negedge clk);
            if (i > 0) begin
                checks += 2;
                if (count !== 3'd1) begin errors++; $display("[TB] FAIL wrap_count[%0d]: got=%0d exp=1", i, count); end
                if (dout !== (8'(1) << ((i - 1) % 8))) begin
                    errors++;
                    $display("[TB] FAIL wrap_dout[%0d]: got=%h exp=%h", i, dout, 8'(1) << ((i - 1) % 8));
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; code_in = 3'bxxx;
        @(negedge clk);
        checks++;
        if (dout !== 8'h08) begin errors++; $display("[TB] FAIL wrap_last: got=%h exp=08", dout); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_empty: out_valid=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; code_in = 3'd7; sb.push_back(8'h80);
        @(posedge clk); #1;
        in_valid = 1'b0; code_in = 3'bxxx;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks += 2;
            if (dout !== 8'h80)     begin errors++; $display("[TB] FAIL hold_dout[%0d]: got=%h exp=80", i, dout); end
            if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid[%0d]: got=%b exp=1", i, out_valid); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_drain: out_valid=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            checks += 2;
            if (int'(count) !== sb.size()) begin errors++; $display("[TB] FAIL rand_count[%0d]: got=%0d exp=%0d", i, count, sb.size()); end
            if (in_ready !== (sb.size() < DEPTH)) begin errors++; $display("[TB] FAIL rand_in_ready[%0d]: got=%b exp=%b", i, in_ready, sb.size() < DEPTH); end
            in_valid  = 1'($urandom_range(0, 1));
            code_in   = 3'($urandom_range(0, 7));
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && sb.size() < DEPTH) sb.push_back(8'(1) << code_in);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; code_in = 3'bxxx; out_ready = 1'b1;
        repeat (DEPTH + 1) @(posedge clk);
        #1;
        checks++;
        if (count !== 3'd0) begin errors++; $display("[TB] FAIL rand_drain_count: got=%0d exp=0", count); end
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; code_in = 3'd0;
        test_reset();
        test_full_sweep();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_hold();
        test_random();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL sb_leftover: %0d expected codes never delivered, exp=0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, exp=finish before limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
